ahb_regfile: RTL and testbench
==============================

# ahb_regfile

Parametrised AHB-Lite slave register file that replaces hand-instantiated per-register macros in peripheral wrappers. It provides NREGS 32-bit registers with per-bit access modes (RW, RO, W1C), byte/halfword write strobes, and programmable wait states. Unmapped or misaligned accesses get an AHB two-cycle ERROR response. It sits between the bus splitter and a peripheral core and exposes flat register/status vectors plus a summary interrupt.

## Interface
Parameters:
- NREGS, 8, number of 32-bit registers (1..64); register i at byte offset 4*i.
- AW, 8, decoded address bits HADDR[AW-1:0]; requires 4*NREGS <= 2**AW.
- WAIT_STATES, 0, data-phase wait cycles for OKAY transfers (0..15).
- RESET_VAL, 0, NREGS*32-bit reset image; register i occupies bits [32*i+31:32*i].
- RW_MASK, all ones, NREGS*32; bits software read/write.
- RO_MASK, 0, NREGS*32; bits read from hw_in, writes ignored.
- W1C_MASK, 0, NREGS*32; bits set by hw_set, cleared by writing 1.

Ports:
- HCLK  in  1  clock.
- HRESET  in  1  **one clock; reset is synchronous and active-high.**
- HSEL  in  1  slave select.
- HADDR  in  32  address; only [AW-1:0] decoded.
- HTRANS  in  2  transfer type; HTRANS[1]=1 (NONSEQ/SEQ) is active.
- HWRITE  in  1  1 = write.
- HSIZE  in  3  0 byte, 1 halfword, 2 word; larger values are errors.
- HREADY  in  1  bus ready; address phase is sampled only when 1.
- HWDATA  in  32  write data (data phase).
- HREADYOUT  out  1  slave ready.
- HRESP  out  1  0 OKAY, 1 ERROR.
- HRDATA  out  32  read data.
- hw_in  in  NREGS*32  values for RO bits.
- hw_set  in  NREGS*32  per-bit set pulses for W1C bits.
- reg_q  out  NREGS*32  stored register image; RO and unassigned bits read 0.
- irq  out  1  OR of all stored W1C bits.

## Operation
- Mask precedence per bit: RO over W1C over RW. Bits in no mask are constant 0 and read 0.
- Address phase accepted when HSEL & HREADY & HTRANS[1]. Capture index HADDR[AW-1:2], byte offset HADDR[1:0], HWRITE and HSIZE, and set a pending flag.
- Error classes:
  - index >= NREGS.
  - HSIZE > 2.
  - halfword access with HADDR[0]=1.
  - word access with HADDR[1:0] != 0.
- Byte strobes:
  - HSIZE 0: lane HADDR[1:0].
  - HSIZE 1: lanes {2,3} if HADDR[1], else {0,1}.
  - HSIZE 2: all four lanes.
- Write commit, in the cycle the data phase completes with OKAY, for strobed bits:
  - RW bit takes HWDATA.
  - W1C bit clears where HWDATA=1.
- W1C set: a hw_set bit sets its stored bit every cycle. A set wins over a same-cycle clear.
- Read: HRDATA = (stored & (RW|W1C)) | (hw_in & RO) of the captured index. Valid in the completing data-phase cycle; 0 at all other times. Reads have no side effects.
- FSM states:
  - IDLE → WAIT when an OKAY transfer is accepted and WAIT_STATES > 0.
  - IDLE → ERR1 when an error transfer is accepted.
  - WAIT: counts WAIT_STATES cycles, then → DONE.
  - DONE: completing cycle, HREADYOUT=1. Accepts a new address phase per the IDLE rules, otherwise → IDLE.
  - ERR1 → ERR2 → IDLE.
  - With WAIT_STATES = 0, an OKAY data phase completes in the cycle after acceptance, with HREADYOUT=1 throughout.
- Idle/BUSY transfers, unselected cycles, and cycles with HREADY=0 from another slave are not captured. They leave all state unchanged.

## Timing
- Reset values:
  - stored bits = RESET_VAL & (RW_MASK|W1C_MASK).
  - HREADYOUT=1, HRESP=0, HRDATA=0.
  - FSM in IDLE, pending cleared.
  - irq = |(RESET_VAL & W1C_MASK).
- HRESET asserted mid-transfer aborts it. No write occurs, and the next cycle shows reset values.
- OKAY latency: the data phase lasts 1 + WAIT_STATES cycles. HREADYOUT=0 for the first WAIT_STATES cycles.
- ERROR: ignores WAIT_STATES.
  - ERR1: HREADYOUT=0, HRESP=1.
  - ERR2: HREADYOUT=1, HRESP=1.
  - No write occurs. HRESP=0 in all other cycles.
- Back-to-back: the next address phase overlaps the completing data-phase cycle. A read of a register written by the immediately preceding transfer returns the new value.
- reg_q and irq reflect a committed write or a hw_set one cycle after the commit/set edge.

## Test plan
- Reset with RESET_VAL reg0=0x12345678 and default masks: reset values above; word read of 0x00 -> 0x12345678, OKAY, 1-cycle data phase.
- Byte write 0xAB to 0x01, then word read 0x00 -> 0x1234AB78. Halfword write 0xBEEF to 0x02, then read -> 0xBEEFAB78. Back-to-back write then read, no idle cycle.
- Reg1 fully W1C: pulse hw_set bits 0 and 4 -> irq=1, read -> 0x11. Write 0x1 -> 0x10, irq still 1. Same-cycle hw_set bit4 and write 0x10 -> bit stays 1.
- Reg2 fully RO with hw_in=0xCAFEF00D: read -> 0xCAFEF00D; write 0 -> reg_q reg2 still 0, reread unchanged.
- Error accesses, each giving HREADYOUT 0 then 1 with HRESP=1 both cycles and no register change:
  - address 4*NREGS.
  - HSIZE=3.
  - halfword at 0x01.
- WAIT_STATES=3: word write then read -> HREADYOUT low exactly 3 cycles each. HRESET asserted in wait cycle 2 of a write -> register keeps its reset value, HREADYOUT=1 next cycle.

Source files
------------

// File: rtl/ahb_regfile_if.sv
// ahb_regfile_if
// AHB-Lite slave-side bus bundle for ahb_regfile.
//   HSEL, HADDR, HTRANS, HWRITE, HSIZE, HREADY, HWDATA : master -> slave
//   HREADYOUT, HRESP, HRDATA                            : slave -> master
// Handshake: an address phase is taken only in a cycle where HSEL, HREADY and
// HTRANS[1] are all high. The data phase ends in the first following cycle
// with HREADYOUT high, and HRESP qualifies that cycle. An ERROR takes two
// cycles: HREADYOUT low, then high, with HRESP high in both cycles.
interface ahb_regfile_if;
    logic        HSEL;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic        HREADY;
    logic [31:0] HWDATA;
    logic        HREADYOUT;
    logic        HRESP;
    logic [31:0] HRDATA;

    modport slave (
        input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HREADY, HWDATA,
        output HREADYOUT, HRESP, HRDATA
    );

    modport master (
        output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HREADY, HWDATA,
        input  HREADYOUT, HRESP, HRDATA
    );
endinterface

// File: rtl/ahb_regfile.sv
// ahb_regfile
// AHB-Lite slave register file with NREGS 32-bit registers. Each bit has an
// access mode: RW, RO (read from hw_in) or W1C (set by hw_set, cleared by a
// write of 1). When a bit is in more than one mask, RO wins over W1C, and
// W1C wins over RW. Writes use byte or halfword lane strobes. OKAY transfers
// get WAIT_STATES data-phase wait cycles. Unmapped or misaligned transfers
// get a two-cycle ERROR response.
// Ports:
//   HCLK, HRESET : clock and synchronous active-high reset
//   bus          : AHB-Lite slave modport (see ahb_regfile_if)
//   hw_in        : values returned for RO bits
//   hw_set       : per-bit set pulses for W1C bits
//   reg_q        : stored register image (RO and unmapped bits are 0)
//   irq          : OR of all stored W1C bits
//   o_fsm_state  : current bus FSM state, for debug
module ahb_regfile #(
    parameter int                  NREGS       = 8,
    parameter int                  AW          = 8,
    parameter int                  WAIT_STATES = 0,
    parameter logic [NREGS*32-1:0] RESET_VAL   = '0,
    parameter logic [NREGS*32-1:0] RW_MASK     = '1,
    parameter logic [NREGS*32-1:0] RO_MASK     = '0,
    parameter logic [NREGS*32-1:0] W1C_MASK    = '0
) (
    input  logic                  HCLK,
    input  logic                  HRESET,
    ahb_regfile_if.slave          bus,
    input  logic [NREGS*32-1:0]   hw_in,
    input  logic [NREGS*32-1:0]   hw_set,
    output logic [NREGS*32-1:0]   reg_q,
    output logic                  irq,
    output logic [2:0]            o_fsm_state
);

    // Apply the mask precedence once, so that each bit lands in at most one class.
    localparam logic [NREGS*32-1:0] RO_EFF  = RO_MASK;
    localparam logic [NREGS*32-1:0] W1C_EFF = W1C_MASK & ~RO_MASK;
    localparam logic [NREGS*32-1:0] RW_EFF  = RW_MASK & ~RO_MASK & ~W1C_MASK;
    localparam logic [NREGS*32-1:0] ST_MASK = RW_EFF | W1C_EFF;
    localparam logic [3:0]          WS_LAST = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;
    localparam logic [AW-2:0]       NREGS_L = (AW-1)'(NREGS);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_WAIT = 3'd1,
        S_DONE = 3'd2,
        S_ERR1 = 3'd3,
        S_ERR2 = 3'd4
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [AW-3:0]       r_idx;
    logic [1:0]          r_off;
    logic                r_write;
    logic [2:0]          r_size;
    logic                r_pend;
    logic [3:0]          r_wcnt;
    logic [NREGS*32-1:0] r_regs;

    logic [AW-3:0]       w_idx;
    logic                w_accept;
    logic                w_err;
    logic                w_commit;
    logic [3:0]          w_lanes;
    logic [31:0]         w_bmask;
    logic [31:0]         w_rd_word;
    logic [NREGS*32-1:0] w_regs_nxt;
    logic                w_unused;

    assign w_idx    = bus.HADDR[AW-1:2];
    // A new address phase is taken only while no data phase is stalled.
    // DONE is included so that back-to-back transfers overlap.
    assign w_accept = ((r_state == S_IDLE) || (r_state == S_DONE)) &&
                      bus.HSEL && bus.HREADY && bus.HTRANS[1];
    assign w_err    = ({1'b0, w_idx} >= NREGS_L) ||
                      (bus.HSIZE > 3'd2) ||
                      ((bus.HSIZE == 3'd1) && bus.HADDR[0]) ||
                      ((bus.HSIZE == 3'd2) && (bus.HADDR[1:0] != 2'b00));
    assign w_commit = (r_state == S_DONE) && r_pend && r_write;
    assign w_unused = &{1'b0, bus.HTRANS[0], bus.HADDR[31:AW]};

    // Transfers that reach DONE are always legal, so the default arm covers words only.
    always_comb begin
        w_lanes = 4'b1111;
        case (r_size)
            3'd0:    w_lanes = 4'b0001 << r_off;
            3'd1:    w_lanes = r_off[1] ? 4'b1100 : 4'b0011;
            default: w_lanes = 4'b1111;
        endcase
    end

    assign w_bmask = {{8{w_lanes[3]}}, {8{w_lanes[2]}}, {8{w_lanes[1]}}, {8{w_lanes[0]}}};

    // hw_set is applied after the bus write, so a set wins over a clear in the same cycle.
    always_comb begin
        w_regs_nxt = r_regs;
        for (int i = 0; i < NREGS; i++) begin
            if (w_commit && (int'(r_idx) == i)) begin
                w_regs_nxt[32*i +: 32] = (r_regs[32*i +: 32] & ~(RW_EFF[32*i +: 32] & w_bmask)) |
                                         (bus.HWDATA & RW_EFF[32*i +: 32] & w_bmask);
                w_regs_nxt[32*i +: 32] = w_regs_nxt[32*i +: 32] &
                                         ~(bus.HWDATA & W1C_EFF[32*i +: 32] & w_bmask);
            end
        end
        w_regs_nxt = (w_regs_nxt | (hw_set & W1C_EFF)) & ST_MASK;
    end

    always_comb begin
        w_rd_word = '0;
        for (int i = 0; i < NREGS; i++) begin
            if (int'(r_idx) == i) begin
                w_rd_word = (r_regs[32*i +: 32] & ST_MASK[32*i +: 32]) |
                            (hw_in[32*i +: 32] & RO_EFF[32*i +: 32]);
            end
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        bus.HREADYOUT = 1'b1;
        bus.HRESP     = 1'b0;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (w_accept) begin
                    if (w_err)                w_state_nxt = S_ERR1;
                    else if (WAIT_STATES > 0) w_state_nxt = S_WAIT;
                    else                      w_state_nxt = S_DONE;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_WAIT: begin
                bus.HREADYOUT = 1'b0;
                if (r_wcnt == WS_LAST) w_state_nxt = S_DONE;
            end
            S_ERR1: begin
                bus.HREADYOUT = 1'b0;
                bus.HRESP     = 1'b1;
                w_state_nxt   = S_ERR2;
            end
            S_ERR2: begin
                bus.HRESP   = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign bus.HRDATA = ((r_state == S_DONE) && r_pend && !r_write) ? w_rd_word : 32'h0;

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            r_state <= S_IDLE;
            r_idx   <= '0;
            r_off   <= 2'b00;
            r_write <= 1'b0;
            r_size  <= 3'd0;
            r_pend  <= 1'b0;
            r_wcnt  <= 4'd0;
            r_regs  <= RESET_VAL & ST_MASK;
        end else begin
            r_state <= w_state_nxt;
            r_regs  <= w_regs_nxt;
            if (w_accept) begin
                r_idx   <= w_idx;
                r_off   <= bus.HADDR[1:0];
                r_write <= bus.HWRITE;
                r_size  <= bus.HSIZE;
                r_pend  <= 1'b1;
                r_wcnt  <= 4'd0;
            end else begin
                if ((r_state == S_DONE) || (r_state == S_ERR2)) r_pend <= 1'b0;
                if (r_state == S_WAIT) r_wcnt <= r_wcnt + 4'd1;
            end
        end
    end

    assign reg_q       = r_regs;
    assign irq         = |(r_regs & W1C_EFF);
    assign o_fsm_state = r_state;

endmodule

// File: tb/tb_ahb_regfile.sv
// tb_ahb_regfile
// Directed and randomized bench for ahb_regfile. It uses two instances that
// share one set of bus signals. HSEL picks the instance:
//   dut0: WAIT_STATES=0, reg1 is fully W1C and reg2 is fully RO.
//   dut1: WAIT_STATES=3, all registers are RW.
// A bit-level reference model, driven by the masks, predicts the read data
// and the stored image.
module tb_ahb_regfile;
    localparam int NR = 8;
    localparam int W  = NR * 32;
    localparam logic [W-1:0] RST_IMG = W'(32'h12345678);
    localparam logic [W-1:0] ONES    = {W{1'b1}};
    localparam logic [W-1:0] W1C0    = W'(32'hFFFFFFFF) << 32;
    localparam logic [W-1:0] RO0     = W'(32'hFFFFFFFF) << 64;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ahb_regfile_if bus0 ();
    ahb_regfile_if bus1 ();

    logic        tb_dsel;
    logic        hsel;
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [31:0] hwdata;
    logic        force_lo;
    logic [1:0]  act_trans;
    logic        hready_mux;
    logic        hreadyout_s;
    logic        hresp_s;
    logic [31:0] hrdata_s;

    logic [W-1:0] hw_in0, hw_in1, hw_set0, hw_set1, reg_q0, reg_q1;
    logic         irq0, irq1;
    logic [2:0]   st_unused0, st_unused1;

    assign hreadyout_s = tb_dsel ? bus1.HREADYOUT : bus0.HREADYOUT;
    assign hresp_s     = tb_dsel ? bus1.HRESP     : bus0.HRESP;
    assign hrdata_s    = tb_dsel ? bus1.HRDATA    : bus0.HRDATA;
    assign hready_mux  = force_lo ? 1'b0 : hreadyout_s;

    assign bus0.HSEL = hsel & ~tb_dsel;
    assign bus1.HSEL = hsel & tb_dsel;
    assign bus0.HADDR = haddr;     assign bus1.HADDR = haddr;
    assign bus0.HTRANS = htrans;   assign bus1.HTRANS = htrans;
    assign bus0.HWRITE = hwrite;   assign bus1.HWRITE = hwrite;
    assign bus0.HSIZE = hsize;     assign bus1.HSIZE = hsize;
    assign bus0.HREADY = hready_mux; assign bus1.HREADY = hready_mux;
    assign bus0.HWDATA = hwdata;   assign bus1.HWDATA = hwdata;

    ahb_regfile #(.NREGS(NR), .AW(8), .WAIT_STATES(0), .RESET_VAL(RST_IMG),
                  .RW_MASK(ONES), .RO_MASK(RO0), .W1C_MASK(W1C0)) u_dut0 (
        .HCLK(clk), .HRESET(rst), .bus(bus0), .hw_in(hw_in0), .hw_set(hw_set0),
        .reg_q(reg_q0), .irq(irq0), .o_fsm_state(st_unused0));

    ahb_regfile #(.NREGS(NR), .AW(8), .WAIT_STATES(3), .RESET_VAL(RST_IMG),
                  .RW_MASK(ONES), .RO_MASK('0), .W1C_MASK('0)) u_dut1 (
        .HCLK(clk), .HRESET(rst), .bus(bus1), .hw_in(hw_in1), .hw_set(hw_set1),
        .reg_q(reg_q1), .irq(irq1), .o_fsm_state(st_unused1));

    // ---------------- reference model ----------------
    logic [W-1:0] mimg [2];
    logic [W-1:0] rw_m [2];
    logic [W-1:0] ro_m [2];
    logic [W-1:0] w1c_m[2];
    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] last_rd;

    function automatic logic exp_err(input logic [31:0] a, input logic [2:0] sz);
        return (a[7:2] >= 6'(NR)) || (sz > 3'd2) || (sz == 3'd1 && a[0]) ||
               (sz == 3'd2 && a[1:0] != 2'b00);
    endfunction

    function automatic logic [3:0] lanes_of(input logic [31:0] a, input logic [2:0] sz);
        if (sz == 3'd0) return 4'b0001 << a[1:0];
        if (sz == 3'd1) return a[1] ? 4'b1100 : 4'b0011;
        return 4'b1111;
    endfunction

    function automatic void model_reset();
        for (int d = 0; d < 2; d++) mimg[d] = RST_IMG & (rw_m[d] | w1c_m[d]) & ~ro_m[d];
    endfunction

    function automatic void model_write(input int d, input int idx, input logic [3:0] ln,
                                        input logic [31:0] wd);
        for (int b = 0; b < 32; b++) begin
            int k;
            k = 32 * idx + b;
            if (ln[b/8]) begin
                if (ro_m[d][k]) begin
                end else if (w1c_m[d][k]) begin
                    if (wd[b]) mimg[d][k] = 1'b0;
                end else if (rw_m[d][k]) begin
                    mimg[d][k] = wd[b];
                end
            end
        end
    endfunction

    function automatic void model_set(input int d, input logic [W-1:0] sv);
        mimg[d] = mimg[d] | (sv & w1c_m[d] & ~ro_m[d]);
    endfunction

    function automatic logic [31:0] model_read(input int d, input int idx);
        logic [31:0] r;
        logic [W-1:0] hin;
        r = '0;
        hin = (d == 0) ? hw_in0 : hw_in1;
        for (int b = 0; b < 32; b++) begin
            int k;
            k = 32 * idx + b;
            if (ro_m[d][k]) r[b] = hin[k];
            else if (w1c_m[d][k] || rw_m[d][k]) r[b] = mimg[d][k];
        end
        return r;
    endfunction

    function automatic logic model_irq(input int d);
        return |(mimg[d] & w1c_m[d] & ~ro_m[d]);
    endfunction

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_image(input int d, input string tag);
        check($sformatf("%s_regq", tag), (d == 0) ? reg_q0 : reg_q1, mimg[d]);
        check($sformatf("%s_irq", tag), W'((d == 0) ? irq0 : irq1), W'(model_irq(d)));
    endtask

    // ---------------- drivers ----------------
    // Entered and left #1 after a rising edge.
    task automatic xfer(input logic [31:0] a, input logic w, input logic [2:0] sz,
                        input logic [31:0] wd, input logic [W-1:0] setv,
                        output logic [31:0] rd, output logic rf, output logic rl,
                        output int waits, output logic done);
        hsel = 1'b1; htrans = act_trans; haddr = a; hwrite = w; hsize = sz;
        @(posedge clk); #1;
        hsel = 1'b0; htrans = 2'b00; hwdata = wd;
        if (tb_dsel) hw_set1 = setv; else hw_set0 = setv;
        waits = 0; done = 1'b0; rf = 1'b0; rl = 1'b0; rd = '0;
        for (int c = 0; c < 40 && !done; c++) begin
            @(negedge clk);
            if (c == 0) rf = hresp_s;
            if (hreadyout_s) begin
                done = 1'b1; rd = hrdata_s; rl = hresp_s;
            end else begin
                waits++;
            end
            @(posedge clk); #1;
        end
        hw_set0 = '0; hw_set1 = '0;
    endtask

    task automatic op(input logic d, input logic [31:0] a, input logic w, input logic [2:0] sz,
                      input logic [31:0] wd, input logic [W-1:0] setv, input string tag);
        logic [31:0] rd, exp_rd;
        logic rf, rl, done, err;
        int waits, idx;
        tb_dsel = d;
        err = exp_err(a, sz);
        idx = int'(a[7:2]);
        exp_rd = err ? 32'h0 : model_read(int'(d), idx);
        xfer(a, w, sz, wd, setv, rd, rf, rl, waits, done);
        check($sformatf("%s_done", tag), W'(done), W'(1'b1));
        check($sformatf("%s_waits", tag), W'(waits), W'(err ? 1 : (d ? 3 : 0)));
        check($sformatf("%s_resp1", tag), W'(rf), W'(err));
        check($sformatf("%s_respN", tag), W'(rl), W'(err));
        if (!err && w) model_write(int'(d), idx, lanes_of(a, sz), wd);
        if (!err && !w) check($sformatf("%s_rdata", tag), W'(rd), W'(exp_rd));
        model_set(int'(d), setv);
        last_rd = rd;
        check_image(int'(d), tag);
    endtask

    task automatic b2b(input logic d, input logic [31:0] aw, input logic [2:0] szw,
                       input logic [31:0] wd, input logic [31:0] ar, input string tag);
        int ww, rw;
        logic done, rsp;
        logic [31:0] rd;
        tb_dsel = d;
        hsel = 1'b1; htrans = 2'b10; haddr = aw; hwrite = 1'b1; hsize = szw;
        @(posedge clk); #1;
        haddr = ar; hwrite = 1'b0; hsize = 3'd2; hwdata = wd;
        ww = 0; done = 1'b0;
        for (int c = 0; c < 40 && !done; c++) begin
            @(negedge clk);
            if (hreadyout_s) done = 1'b1; else ww++;
            @(posedge clk); #1;
        end
        check($sformatf("%s_wdone", tag), W'(done), W'(1'b1));
        hsel = 1'b0; htrans = 2'b00;
        model_write(int'(d), int'(aw[7:2]), lanes_of(aw, szw), wd);
        rw = 0; done = 1'b0; rsp = 1'b0; rd = '0;
        for (int c = 0; c < 40 && !done; c++) begin
            @(negedge clk);
            if (hreadyout_s) begin
                done = 1'b1; rd = hrdata_s; rsp = hresp_s;
            end else begin
                rw++;
            end
            @(posedge clk); #1;
        end
        check($sformatf("%s_rdone", tag), W'(done), W'(1'b1));
        check($sformatf("%s_wwaits", tag), W'(ww), W'(d ? 3 : 0));
        check($sformatf("%s_rwaits", tag), W'(rw), W'(d ? 3 : 0));
        check($sformatf("%s_rresp", tag), W'(rsp), W'(1'b0));
        check($sformatf("%s_rdata", tag), W'(rd), W'(model_read(int'(d), int'(ar[7:2]))));
        last_rd = rd;
        check_image(int'(d), tag);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    // ---------------- directed + random sequence ----------------
    initial begin
        logic [W-1:0] sv;
        logic [31:0]  ra;
        rst = 1'b1; tb_dsel = 1'b0; hsel = 1'b0; haddr = '0; htrans = 2'b00;
        hwrite = 1'b0; hsize = 3'd2; hwdata = '0; force_lo = 1'b0; act_trans = 2'b10;
        hw_set0 = '0; hw_set1 = '0;
        for (int i = 0; i < NR; i++) begin
            hw_in0[32*i +: 32] = $urandom();
            hw_in1[32*i +: 32] = $urandom();
        end
        hw_in0[64 +: 32] = 32'hCAFEF00D;
        rw_m[0] = ONES; ro_m[0] = RO0; w1c_m[0] = W1C0;
        rw_m[1] = ONES; ro_m[1] = '0;  w1c_m[1] = '0;
        model_reset();

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst0_hreadyout", W'(bus0.HREADYOUT), W'(1'b1));
        check("rst0_hresp", W'(bus0.HRESP), W'(1'b0));
        check("rst0_hrdata", W'(bus0.HRDATA), W'(0));
        check("rst1_hreadyout", W'(bus1.HREADYOUT), W'(1'b1));
        check("rst1_hrdata", W'(bus1.HRDATA), W'(0));
        check_image(0, "rst0");
        check_image(1, "rst1");
        @(posedge clk); #1;

        op(1'b0, 32'h00, 1'b0, 3'd2, 32'h0, '0, "rd_reset_reg0");
        check("rd_reset_reg0_const", W'(last_rd), W'(32'h12345678));
        op(1'b0, 32'h01, 1'b1, 3'd0, 32'hABABABAB, '0, "wr_byte1");
        op(1'b0, 32'h00, 1'b0, 3'd2, 32'h0, '0, "rd_after_byte");
        check("rd_after_byte_const", W'(last_rd), W'(32'h1234AB78));
        b2b(1'b0, 32'h02, 3'd1, 32'hBEEFBEEF, 32'h00, "b2b_half");
        check("b2b_half_const", W'(last_rd), W'(32'hBEEFAB78));

        // W1C register 1
        hw_set0 = W'(32'h11) << 32;
        @(posedge clk); #1 hw_set0 = '0;
        model_set(0, W'(32'h11) << 32);
        @(negedge clk);
        check("w1c_set_irq", W'(irq0), W'(1'b1));
        check("w1c_set_word", W'(reg_q0[63:32]), W'(32'h11));
        @(posedge clk); #1;
        op(1'b0, 32'h04, 1'b0, 3'd2, 32'h0, '0, "w1c_rd1");
        check("w1c_rd1_const", W'(last_rd), W'(32'h11));
        op(1'b0, 32'h04, 1'b1, 3'd2, 32'h1, '0, "w1c_clr0");
        op(1'b0, 32'h04, 1'b0, 3'd2, 32'h0, '0, "w1c_rd2");
        check("w1c_rd2_const", W'(last_rd), W'(32'h10));
        check("w1c_rd2_irq", W'(irq0), W'(1'b1));
        op(1'b0, 32'h04, 1'b1, 3'd2, 32'h10, W'(32'h10) << 32, "w1c_setwins");
        op(1'b0, 32'h04, 1'b0, 3'd2, 32'h0, '0, "w1c_rd3");
        check("w1c_rd3_const", W'(last_rd), W'(32'h10));
        op(1'b0, 32'h04, 1'b1, 3'd2, 32'h10, '0, "w1c_clr4");
        check("w1c_clr4_irq", W'(irq0), W'(1'b0));

        // RO register 2
        op(1'b0, 32'h08, 1'b0, 3'd2, 32'h0, '0, "ro_rd1");
        check("ro_rd1_const", W'(last_rd), W'(32'hCAFEF00D));
        op(1'b0, 32'h08, 1'b1, 3'd2, 32'h0, '0, "ro_wr");
        check("ro_wr_regq2", W'(reg_q0[95:64]), W'(0));
        op(1'b0, 32'h08, 1'b0, 3'd2, 32'h0, '0, "ro_rd2");

        // Error transfers
        op(1'b0, 32'h20, 1'b1, 3'd2, 32'hFFFFFFFF, '0, "err_unmapped");
        op(1'b0, 32'h00, 1'b1, 3'd3, 32'hFFFFFFFF, '0, "err_size3");
        op(1'b0, 32'h01, 1'b1, 3'd1, 32'hFFFFFFFF, '0, "err_half_odd");
        op(1'b0, 32'h02, 1'b0, 3'd2, 32'h0, '0, "err_word_mis");

        // Transfers that must not be captured: HREADY low, BUSY, unselected
        for (int k = 0; k < 3; k++) begin
            tb_dsel = 1'b0; hwrite = 1'b1; haddr = 32'h0; hsize = 3'd2;
            hsel = (k != 2); htrans = (k == 1) ? 2'b01 : 2'b10; force_lo = (k == 0);
            @(posedge clk); #1;
            hsel = 1'b0; htrans = 2'b00; force_lo = 1'b0; hwdata = 32'hFFFFFFFF;
            @(negedge clk);
            check($sformatf("nocap%0d_hreadyout", k), W'(bus0.HREADYOUT), W'(1'b1));
            check($sformatf("nocap%0d_hresp", k), W'(bus0.HRESP), W'(1'b0));
            @(posedge clk); #1;
            check_image(0, $sformatf("nocap%0d", k));
        end

        // Randomized traffic on the zero-wait instance
        for (int n = 0; n < 80; n++) begin
            ra = ($urandom() & 32'hFFFFFF00) | 32'($urandom_range(0, 39));
            sv = '0;
            if ($urandom_range(0, 3) == 0)
                for (int i = 0; i < NR; i++) sv[32*i +: 32] = $urandom() & $urandom();
            act_trans = ($urandom_range(0, 1) == 1) ? 2'b11 : 2'b10;
            op(1'b0, ra, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 3)), $urandom(), sv,
               $sformatf("rnd%0d", n));
        end
        act_trans = 2'b10;

        // Wait-state instance
        b2b(1'b1, 32'h00, 3'd2, 32'hA5A55A5A, 32'h00, "ws_b2b");
        check("ws_b2b_const", W'(last_rd), W'(32'hA5A55A5A));
        for (int n = 0; n < 10; n++) begin
            ra = 32'($urandom_range(0, 39));
            op(1'b1, ra, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 3)), $urandom(), '0,
               $sformatf("wsrnd%0d", n));
        end

        // Reset during wait cycle 2 of a write aborts it
        tb_dsel = 1'b1; hsel = 1'b1; htrans = 2'b10; haddr = 32'h0C; hwrite = 1'b1; hsize = 3'd2;
        @(posedge clk); #1;
        hsel = 1'b0; htrans = 2'b00; hwdata = 32'hFFFFFFFF;
        @(negedge clk);
        check("wsrst_wait1", W'(hreadyout_s), W'(1'b0));
        @(posedge clk); #1 rst = 1'b1;
        @(negedge clk);
        check("wsrst_wait2", W'(hreadyout_s), W'(1'b0));
        @(posedge clk); #1 rst = 1'b0;
        model_reset();
        @(negedge clk);
        check("wsrst_hreadyout", W'(bus1.HREADYOUT), W'(1'b1));
        check("wsrst_hresp", W'(bus1.HRESP), W'(1'b0));
        check("wsrst_reg3", W'(reg_q1[127:96]), W'(0));
        check_image(1, "wsrst1");
        check_image(0, "wsrst0");
        @(posedge clk); #1;
        op(1'b1, 32'h0C, 1'b0, 3'd2, 32'h0, '0, "wsrst_rd3");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
